jt12_acc_seq: RTL and testbench

Slot sequencer and channel-configuration store for the FM accumulator datapath. Runs a 24-slot operator frame: 6 channels × 4 operators, in the order S1, S3, S2, S4. Each slot it presents the per-slot control the accumulator consumes: frame-start `zero`, `s1..s4_enters`, `ch6op`, the current channel's `alg`/`rl`, and `pcm_en`. It holds the per-channel configuration written by the register interface and emits a sample-valid strobe when a frame completes.

---
 rtl/jt12_acc_seq_pkg.sv | 16 +
 rtl/jt12_acc_seq_if.sv | 30 +++
 rtl/jt12_seq_cfg.sv | 80 ++++++++
 rtl/jt12_acc_seq.sv | 118 +++++++++++
 tb/tb_jt12_acc_seq.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/jt12_acc_seq_pkg.sv
// Shared types for the jt12 accumulator slot sequencer: frame geometry,
// operator-group order and the per-channel config entry.
package jt12_seq_pkg;
    localparam int NUM_CH = 6;
    localparam int SLOTS  = 4 * NUM_CH;

    // Encoding follows frame order, so incrementing walks the frame.
    typedef enum logic [1:0] {GRP_S1, GRP_S3, GRP_S2, GRP_S4} grp_e;

    typedef struct packed {
        logic [2:0] alg;
        logic [1:0] rl;
    } cfg_t;

    localparam cfg_t CFG_RST = '{alg: 3'd0, rl: 2'b11};
endpackage

// File: rtl/jt12_acc_seq_if.sv
// Sequencer bus: slot-advance enable, config write port and per-slot controls.
interface jt12_acc_seq_if;
    logic       clk_en;
    logic       cfg_we;
    logic [2:0] cfg_ch;
    logic [2:0] cfg_alg;
    logic [1:0] cfg_rl;
    logic       cfg_pcm_we;
    logic       cfg_pcm_en;
    logic [4:0] slot;
    logic [2:0] ch;
    logic       zero;
    logic       s1_enters, s2_enters, s3_enters, s4_enters;
    logic       ch6op;
    logic [2:0] alg;
    logic [1:0] rl;
    logic       pcm_en;
    logic       sample_vld;

    modport master (
        output clk_en, cfg_we, cfg_ch, cfg_alg, cfg_rl, cfg_pcm_we, cfg_pcm_en,
        input  slot, ch, zero, s1_enters, s2_enters, s3_enters, s4_enters,
               ch6op, alg, rl, pcm_en, sample_vld
    );
    modport slave (
        input  clk_en, cfg_we, cfg_ch, cfg_alg, cfg_rl, cfg_pcm_we, cfg_pcm_en,
        output slot, ch, zero, s1_enters, s2_enters, s3_enters, s4_enters,
               ch6op, alg, rl, pcm_en, sample_vld
    );
endinterface

// File: rtl/jt12_seq_cfg.sv
// Per-channel alg/rl bank plus PCM enable. With JT12_SEQ_SHADOW_EN a staging
// bank collects writes and is copied to the active bank on commit_i.
module jt12_seq_cfg
    import jt12_seq_pkg::*;
#(
    parameter int NUM_CH = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       we_i,
    input  logic [2:0] wch_i,
    input  cfg_t       wdata_i,
    input  logic       pcm_we_i,
    input  logic       pcm_wdata_i,
`ifdef JT12_SEQ_SHADOW_EN
    input  logic       commit_i,
`endif
    input  logic [2:0] rd_idx_i,
    output cfg_t       rd_data_o,
    output logic       pcm_o
);
    cfg_t act_q [NUM_CH];
    cfg_t act_d [NUM_CH];
    logic pcm_q, pcm_d;
    logic wr_ok;

    assign wr_ok = we_i && (int'(wch_i) < NUM_CH);

`ifdef JT12_SEQ_SHADOW_EN
    cfg_t stg_q [NUM_CH];
    cfg_t stg_d [NUM_CH];
    logic stg_pcm_q, stg_pcm_d;

    // A write on the commit edge lands in stg_d and is carried straight through.
    always_comb begin
        stg_d     = stg_q;
        stg_pcm_d = stg_pcm_q;
        if (wr_ok)    stg_d[wch_i] = wdata_i;
        if (pcm_we_i) stg_pcm_d    = pcm_wdata_i;
        act_d = act_q;
        pcm_d = pcm_q;
        if (commit_i) begin
            act_d = stg_d;
            pcm_d = stg_pcm_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_q     <= '{default: CFG_RST};
            stg_pcm_q <= 1'b0;
        end else begin
            stg_q     <= stg_d;
            stg_pcm_q <= stg_pcm_d;
        end
    end
`else
    always_comb begin
        act_d = act_q;
        pcm_d = pcm_q;
        if (wr_ok)    act_d[wch_i] = wdata_i;
        if (pcm_we_i) pcm_d        = pcm_wdata_i;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q <= '{default: CFG_RST};
            pcm_q <= 1'b0;
        end else begin
            act_q <= act_d;
            pcm_q <= pcm_d;
        end
    end

    // Read port returns the value active after this edge, so the output
    // register picks up same-cycle writes and commits.
    assign rd_data_o = act_d[rd_idx_i];
    assign pcm_o     = pcm_d;
endmodule

// File: rtl/jt12_acc_seq.sv
// 24-slot operator-frame sequencer for the jt12 accumulator (S1,S3,S2,S4 x 6 ch).
// Define JT12_SEQ_SHADOW_EN to make config changes take effect only at frame start.
module jt12_acc_seq
    import jt12_seq_pkg::*;
#(
    parameter int NUM_CH = 6
) (
    input  logic           clk,
    input  logic           rst,
    jt12_acc_seq_if.slave  seq_if
);
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;
    localparam logic [4:0] SLOT_LAST = 5'(4 * NUM_CH - 1);
    localparam logic [2:0] CH_LAST   = 3'(NUM_CH - 1);

    logic [0:0] st_q, st_d;
    logic [4:0] slot_q, slot_d;
    logic [2:0] ch_q, ch_d;
    grp_e       grp_q, grp_d;
    logic       zero_q, s1_q, s2_q, s3_q, s4_q, ch6op_q, svld_q, pcm_q;
    cfg_t       cfg_q;
    cfg_t       rd_cfg;
    logic       rd_pcm;
    logic       run, adv, commit;

    assign run    = (st_q == ST_RUN);
    assign adv    = seq_if.clk_en;
    assign commit = run && adv && (slot_q == SLOT_LAST);

    // Channel and group are nested counters; grp steps when ch wraps.
    always_comb begin
        st_d   = st_q;
        slot_d = slot_q;
        ch_d   = ch_q;
        grp_d  = grp_q;
        if (adv) begin
            st_d = ST_RUN;
            if (!run) begin
                slot_d = '0;
                ch_d   = '0;
                grp_d  = GRP_S1;
            end else begin
                slot_d = commit ? 5'd0 : slot_q + 5'd1;
                if (ch_q == CH_LAST) begin
                    ch_d  = '0;
                    grp_d = grp_e'(grp_q + 2'd1);
                end else begin
                    ch_d = ch_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            slot_q  <= '0;
            ch_q    <= '0;
            grp_q   <= GRP_S1;
            zero_q  <= 1'b0;
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            s4_q    <= 1'b0;
            ch6op_q <= 1'b0;
            svld_q  <= 1'b0;
            pcm_q   <= 1'b0;
            cfg_q   <= CFG_RST;
        end else begin
            st_q   <= st_d;
            slot_q <= slot_d;
            ch_q   <= ch_d;
            grp_q  <= grp_d;
            svld_q <= commit;
            if (adv) begin
                zero_q  <= (slot_d == 5'd0);
                s1_q    <= (grp_d == GRP_S1);
                s2_q    <= (grp_d == GRP_S2);
                s3_q    <= (grp_d == GRP_S3);
                s4_q    <= (grp_d == GRP_S4);
                ch6op_q <= (ch_d == CH_LAST);
                pcm_q   <= rd_pcm;
            end
            // While running, track the bank every cycle so direct writes show at once.
            if (adv || run) cfg_q <= rd_cfg;
        end
    end

    jt12_seq_cfg #(.NUM_CH(NUM_CH)) u_cfg (
        .clk         (clk),
        .rst         (rst),
        .we_i        (seq_if.cfg_we),
        .wch_i       (seq_if.cfg_ch),
        .wdata_i     ('{alg: seq_if.cfg_alg, rl: seq_if.cfg_rl}),
        .pcm_we_i    (seq_if.cfg_pcm_we),
        .pcm_wdata_i (seq_if.cfg_pcm_en),
`ifdef JT12_SEQ_SHADOW_EN
        .commit_i    (commit),
`endif
        .rd_idx_i    (ch_d),
        .rd_data_o   (rd_cfg),
        .pcm_o       (rd_pcm)
    );

    assign seq_if.slot       = slot_q;
    assign seq_if.ch         = ch_q;
    assign seq_if.zero       = zero_q;
    assign seq_if.s1_enters  = s1_q;
    assign seq_if.s2_enters  = s2_q;
    assign seq_if.s3_enters  = s3_q;
    assign seq_if.s4_enters  = s4_q;
    assign seq_if.ch6op      = ch6op_q;
    assign seq_if.alg        = cfg_q.alg;
    assign seq_if.rl         = cfg_q.rl;
    assign seq_if.pcm_en     = pcm_q;
    assign seq_if.sample_vld = svld_q;
endmodule

// File: tb/tb_jt12_acc_seq.sv
// Self-checking bench for jt12_acc_seq: frame-level model plus directed literals.
module tb_jt12_acc_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    jt12_acc_seq_if sif ();
    jt12_acc_seq #(.NUM_CH(6)) dut (.clk(clk), .rst(rst), .seq_if(sif.slave));

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int svld_cnt = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: frame position as a plain slot number, banks as integer arrays.
    bit m_run = 0;
    int m_slot = 0;
    bit m_svld = 0;
    int m_act_alg [6];
    int m_act_rl  [6];
    int m_stg_alg [6];
    int m_stg_rl  [6];
    bit m_pcm_act = 0, m_pcm_stg = 0, m_pcm_shown = 0;

    task automatic model_reset();
        m_run = 0; m_slot = 0; m_svld = 0;
        m_pcm_act = 0; m_pcm_stg = 0; m_pcm_shown = 0;
        for (int i = 0; i < 6; i++) begin
            m_act_alg[i] = 0; m_act_rl[i] = 3;
            m_stg_alg[i] = 0; m_stg_rl[i] = 3;
        end
    endtask

    initial model_reset();

    always @(posedge clk or posedge rst) begin : model
        bit wrap;
        if (rst) model_reset();
        else begin
            wrap = sif.clk_en && m_run && (m_slot == 23);
`ifdef JT12_SEQ_SHADOW_EN
            if (sif.cfg_we && sif.cfg_ch < 6) begin
                m_stg_alg[sif.cfg_ch] = sif.cfg_alg;
                m_stg_rl[sif.cfg_ch]  = sif.cfg_rl;
            end
            if (sif.cfg_pcm_we) m_pcm_stg = sif.cfg_pcm_en;
            if (wrap) begin
                for (int i = 0; i < 6; i++) begin
                    m_act_alg[i] = m_stg_alg[i];
                    m_act_rl[i]  = m_stg_rl[i];
                end
                m_pcm_act = m_pcm_stg;
            end
`else
            if (sif.cfg_we && sif.cfg_ch < 6) begin
                m_act_alg[sif.cfg_ch] = sif.cfg_alg;
                m_act_rl[sif.cfg_ch]  = sif.cfg_rl;
            end
            if (sif.cfg_pcm_we) m_pcm_act = sif.cfg_pcm_en;
`endif
            if (sif.clk_en) begin
                m_pcm_shown = m_pcm_act;
                if (m_run) m_slot = (m_slot + 1) % 24;
                else begin m_run = 1; m_slot = 0; end
            end
            m_svld = wrap;
        end
    end

    always @(negedge clk) begin : compare
        int s, c, g;
        if (chk_en) begin
            s = m_slot; c = s % 6; g = s / 6;
            chk("slot",  sif.slot, s);
            chk("ch",    sif.ch, c);
            chk("zero",  sif.zero, int'(m_run && s == 0));
            chk("s1",    sif.s1_enters, int'(m_run && g == 0));
            chk("s3",    sif.s3_enters, int'(m_run && g == 1));
            chk("s2",    sif.s2_enters, int'(m_run && g == 2));
            chk("s4",    sif.s4_enters, int'(m_run && g == 3));
            chk("ch6op", sif.ch6op, int'(m_run && c == 5));
            chk("alg",   sif.alg, m_run ? m_act_alg[c] : 0);
            chk("rl",    sif.rl,  m_run ? m_act_rl[c]  : 3);
            chk("pcm_en", sif.pcm_en, int'(m_pcm_shown));
            chk("sample_vld", sif.sample_vld, int'(m_svld));
            if (sif.sample_vld) svld_cnt++;
        end
    end

    task automatic step(input bit en, input bit we = 0, input logic [2:0] c = 0,
                        input logic [2:0] a = 0, input logic [1:0] r = 0,
                        input bit pwe = 0, input bit pen = 0);
        sif.clk_en = en; sif.cfg_we = we; sif.cfg_ch = c; sif.cfg_alg = a;
        sif.cfg_rl = r; sif.cfg_pcm_we = pwe; sif.cfg_pcm_en = pen;
        @(posedge clk); #1;
        sif.clk_en = 0; sif.cfg_we = 0; sif.cfg_pcm_we = 0;
    endtask

    task automatic adv_to(input int t);
        for (int i = 0; i < 48 && !(m_run && m_slot == t); i++) step(1);
        chk("adv_to_bound", m_slot, t);
    endtask

    initial begin
        rst = 1;
        sif.clk_en = 0; sif.cfg_we = 0; sif.cfg_ch = 0; sif.cfg_alg = 0;
        sif.cfg_rl = 0; sif.cfg_pcm_we = 0; sif.cfg_pcm_en = 0;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk_en = 1;
        chk("lit_rst_slot", sif.slot, 0);
        chk("lit_rst_zero", sif.zero, 0);
        chk("lit_rst_s1", sif.s1_enters, 0);
        chk("lit_rst_rl", sif.rl, 3);
        chk("lit_rst_svld", sif.sample_vld, 0);
        step(0);

        // 49 back-to-back enables: two full frames plus slot 0 again.
        svld_cnt = 0;
        for (int k = 1; k <= 49; k++) begin
            step(1);
            if (k == 1)  chk("lit_first_zero", sif.zero, 1);
            if (k == 6)  chk("lit_slot5_ch6op", sif.ch6op, 1);
            if (k == 13) chk("lit_slot12_s2", sif.s2_enters, 1);
            if (k == 20) chk("lit_slot19_s4", sif.s4_enters, 1);
        end
        chk("lit_49_slot", sif.slot, 0);
        step(0);
        chk("lit_svld_twice", svld_cnt, 2);

        // One enable every 6 clocks: one wrap, one-clock sample_vld.
        svld_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            step(1);
            repeat (5) step(0);
        end
        chk("lit_svld_width", svld_cnt, 1);

        // ch2 write mid-frame.
        adv_to(14);
        step(0, 1, 3'd2, 3'd5, 2'b01);
        adv_to(20);
`ifdef JT12_SEQ_SHADOW_EN
        chk("lit_shadow_s20_alg", sif.alg, 0);
        chk("lit_shadow_s20_rl", sif.rl, 3);
`else
        chk("lit_direct_s20_alg", sif.alg, 5);
        chk("lit_direct_s20_rl", sif.rl, 1);
`endif
        adv_to(2);
        chk("lit_s2_alg", sif.alg, 5);
        chk("lit_s2_rl", sif.rl, 1);

        // Write coincident with the frame wrap.
        adv_to(23);
        step(1, 1, 3'd3, 3'd6, 2'b10);
        adv_to(3);
        chk("lit_wrap_wr_alg", sif.alg, 6);
        chk("lit_wrap_wr_rl", sif.rl, 2);

        // Out-of-range channel, then PCM enable.
        step(0, 1, 3'd6, 3'd7, 2'b00);
        step(0, 0, 3'd0, 3'd0, 2'b00, 1, 1);
        step(1);
`ifdef JT12_SEQ_SHADOW_EN
        chk("lit_pcm_before_commit", sif.pcm_en, 0);
`else
        chk("lit_pcm_next_en", sif.pcm_en, 1);
`endif
        adv_to(3);
        chk("lit_pcm_after_frame", sif.pcm_en, 1);
        chk("lit_ch6_ignored_alg", sif.alg, 6);

        // Reset mid-frame.
        adv_to(13);
        rst = 1;
        #1;
        chk("lit_mrst_slot", sif.slot, 0);
        chk("lit_mrst_s2", sif.s2_enters, 0);
        chk("lit_mrst_alg", sif.alg, 0);
        chk("lit_mrst_rl", sif.rl, 3);
        chk("lit_mrst_pcm", sif.pcm_en, 0);
        @(posedge clk); #1 rst = 0;
        step(0);
        step(1);
        chk("lit_post_slot", sif.slot, 0);
        chk("lit_post_zero", sif.zero, 1);
        chk("lit_post_s1", sif.s1_enters, 1);
        chk("lit_post_svld", sif.sample_vld, 0);
        repeat (8) step(1);
        step(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
